// File: rtl/wavegen_pkg.sv
// wavegen_pkg: waveform mode encoding shared by the DDS core and its shaper.
package wavegen_pkg;

    typedef enum logic [1:0] {
        WAVE_TRI    = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_SQR    = 2'd2,
        WAVE_RAMPDN = 2'd3
    } wave_mode_e;

    function automatic int mode_width();
        return $bits(wave_mode_e);
    endfunction

    localparam int MODE_W = mode_width();

endpackage

// File: rtl/wave_shaper.sv
// wave_shaper: combinational phase-to-sample shaper (triangle, saw, square, ramp-down).
module wave_shaper
    import wavegen_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [OUT_W-1:0] a,
    input  wave_mode_e       mode,
    input  logic [OUT_W-1:0] duty,
    output logic [OUT_W-1:0] sample
);

    localparam logic [OUT_W-1:0] H  = OUT_W'(2 ** (OUT_W - 1));
    localparam logic [OUT_W-1:0] Q  = OUT_W'(2 ** (OUT_W - 2));
    localparam logic [OUT_W-1:0] Q3 = OUT_W'(3 * 2 ** (OUT_W - 2));

    logic [OUT_W-1:0] a2;
    logic [OUT_W-1:0] tri_v;

    // Every triangle branch lands in [0, M], so evaluating mod 2^N (3H == H there)
    // gives the same bits as the N+1 bit formulation.
    always_comb begin
        a2     = {a[OUT_W-2:0], 1'b0};
        tri_v  = a < Q ? H + a2 : a == Q ? '1 : a < Q3 ? H - a2 : a2 - H;
        sample = mode == WAVE_TRI ? tri_v :
                 mode == WAVE_SAW ? a :
                 mode == WAVE_SQR ? {OUT_W{a < duty}} : ~a;
    end

endmodule

// File: rtl/phase_wavegen.sv
// phase_wavegen: DDS phase accumulator with shadowed config applied at phase wrap,
// driving the computed wave shaper into registered wave/sync outputs.
module phase_wavegen
    import wavegen_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int ACC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ACC_W-1:0]  cfg_freq,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [OUT_W-1:0]  cfg_duty,
    output logic [OUT_W-1:0]  wave,
    output logic              sync
);

    localparam logic [OUT_W-1:0] H = OUT_W'(2 ** (OUT_W - 1));

    logic [ACC_W-1:0] phase_q, phase_d, freq_q, freq_d, sh_freq_q, sh_freq_d, sum;
    logic [OUT_W-1:0] duty_q, duty_d, sh_duty_q, sh_duty_d, wave_q, wave_d, sample;
    wave_mode_e       mode_q, mode_d, sh_mode_q, sh_mode_d;
    logic             pend_q, pend_d, sync_q, sync_d;
    logic             carry, accept, apply;

    wave_shaper #(.OUT_W(OUT_W)) u_shaper (
        .a      (phase_q[ACC_W-1 -: OUT_W]),
        .mode   (mode_q),
        .duty   (duty_q),
        .sample (sample)
    );

    // A zero-frequency core never wraps, so a pending config is applied at once.
    always_comb begin
        {carry, sum} = {1'b0, phase_q} + {1'b0, freq_q};
        accept       = cfg_valid && !pend_q;
        apply        = pend_q && ((ena && carry) || freq_q == '0);
        sh_freq_d    = accept ? cfg_freq : sh_freq_q;
        sh_mode_d    = accept ? wave_mode_e'(cfg_mode) : sh_mode_q;
        sh_duty_d    = accept ? cfg_duty : sh_duty_q;
        pend_d       = apply ? 1'b0 : accept ? 1'b1 : pend_q;
        freq_d       = apply ? sh_freq_q : freq_q;
        mode_d       = apply ? sh_mode_q : mode_q;
        duty_d       = apply ? sh_duty_q : duty_q;
        phase_d      = ena ? sum : phase_q;
        wave_d       = ena ? sample : wave_q;
        sync_d       = ena && carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= '0;
            freq_q    <= '0;
            mode_q    <= WAVE_TRI;
            duty_q    <= H;
            sh_freq_q <= '0;
            sh_mode_q <= WAVE_TRI;
            sh_duty_q <= H;
            pend_q    <= 1'b0;
            wave_q    <= H;
            sync_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            freq_q    <= freq_d;
            mode_q    <= mode_d;
            duty_q    <= duty_d;
            sh_freq_q <= sh_freq_d;
            sh_mode_q <= sh_mode_d;
            sh_duty_q <= sh_duty_d;
            pend_q    <= pend_d;
            wave_q    <= wave_d;
            sync_q    <= sync_d;
        end
    end

    assign cfg_ready = !pend_q;
    assign wave      = wave_q;
    assign sync      = sync_q;

endmodule
